// File: rtl/pipeline_elastic_stage_pkg.sv
// Shared types for the inter-stage pipeline registers: legacy control states,
// per-stage bundles and their NOP patterns.
package pipeline_elastic_stage_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_t;

  // addi x0,x0,0 keeps IF/ID decodable while the stage is empty
  localparam if_id_t IF_ID_NOP = '{pc: 32'h0, instr: 32'h0000_0013};
  localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/pipeline_elastic_stage_if.sv
// Valid/ready/data handshake carrying one WIDTH-bit stage bundle.
interface pipeline_elastic_stage_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_elastic_stage_ring_buf.sv
// DEPTH-entry circular store with read/write pointers and occupancy count.
// The caller guarantees push never lands on a full buffer without a pop.
module pipeline_elastic_stage_ring_buf
  import pipeline_elastic_stage_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Explicit wrap so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= BUBBLE;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pipeline_elastic_stage.sv
// Elastic register between two pipeline stages: valid/ready handshake,
// DEPTH-entry buffer, flush to bubble and hold to freeze the output side.
module pipeline_elastic_stage
  import pipeline_elastic_stage_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       hold,
  pipeline_elastic_stage_if.slave    up,
  pipeline_elastic_stage_if.master   dn,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic             not_empty;
  logic             push;
  logic             pop;

  assign not_empty = (count != '0);
  assign pop       = not_empty & dn.ready & ~hold;
  // Full buffer still accepts when the head leaves in the same cycle
  assign up.ready  = (count < CW'(DEPTH)) | pop;
  assign push      = up.valid & up.ready & ~flush;

  pipeline_elastic_stage_ring_buf #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .BUBBLE (BUBBLE)
  ) u_ring (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (up.data),
    .rdata (head),
    .count (count)
  );

  assign dn.valid  = not_empty;
  assign dn.data   = not_empty ? head : BUBBLE;
  assign occupancy = count;

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// Scoreboard bench: a DEPTH=2 stage for directed handshake/flush/hold cases
// and a DEPTH=3 stage for random traffic and mid-stream reset.
module tb_pipeline_elastic_stage;
  import pipeline_elastic_stage_pkg::*;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic nRST;
  logic a_flush, a_hold, b_flush, b_hold;
  logic [1:0] a_occ, b_occ;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] qa [$];
  logic [W-1:0] qb [$];

  always #5 CLK = ~CLK;

  pipeline_elastic_stage_if #(.WIDTH(W)) a_up ();
  pipeline_elastic_stage_if #(.WIDTH(W)) a_dn ();
  pipeline_elastic_stage_if #(.WIDTH(W)) b_up ();
  pipeline_elastic_stage_if #(.WIDTH(W)) b_dn ();

  pipeline_elastic_stage #(.WIDTH(W), .DEPTH(2), .BUBBLE('0)) u_dut_a (
    .CLK(CLK), .nRST(nRST), .flush(a_flush), .hold(a_hold),
    .up(a_up), .dn(a_dn), .occupancy(a_occ)
  );

  pipeline_elastic_stage #(.WIDTH(W), .DEPTH(3), .BUBBLE('0)) u_dut_b (
    .CLK(CLK), .nRST(nRST), .flush(b_flush), .hold(b_hold),
    .up(b_up), .dn(b_dn), .occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      chk("a_occ", W'(a_occ), W'(qa.size()));
      if (!a_dn.valid) chk("a_bubble", a_dn.data, '0);
      if (a_flush) qa.delete();
      else begin
        if (a_dn.valid && a_dn.ready && !a_hold) begin
          if (qa.size() == 0) chk("a_sb_nonempty", W'(qa.size()), 1);
          else chk("a_pop", a_dn.data, qa.pop_front());
        end
        if (a_up.valid && a_up.ready) qa.push_back(a_up.data);
      end
    end
  end

  always @(negedge CLK) begin
    if (nRST) begin
      chk("b_occ", W'(b_occ), W'(qb.size()));
      chk("b_occ_max", W'(b_occ <= 2'd3), 1);
      if (!b_dn.valid) chk("b_bubble", b_dn.data, '0);
      if (b_flush) qb.delete();
      else begin
        if (b_dn.valid && b_dn.ready && !b_hold) begin
          if (qb.size() == 0) chk("b_sb_nonempty", W'(qb.size()), 1);
          else chk("b_pop", b_dn.data, qb.pop_front());
        end
        if (b_up.valid && b_up.ready) qb.push_back(b_up.data);
      end
    end
  end

  task automatic drive_a(input logic v, input logic [W-1:0] d);
    @(posedge CLK); #1;
    a_up.valid = v;
    a_up.data  = d;
  endtask

  initial begin
    logic [W-1:0] seq [3];
    nRST = 1'b0;
    a_flush = 0; a_hold = 0; b_flush = 0; b_hold = 0;
    a_up.valid = 0; a_up.data = '0; a_dn.ready = 0;
    b_up.valid = 0; b_up.data = '0; b_dn.ready = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // 1: reset state
    chk("t1_out_valid", W'(a_dn.valid), 0);
    chk("t1_out_data",  a_dn.data, '0);
    chk("t1_in_ready",  W'(a_up.ready), 1);
    chk("t1_occ",       W'(a_occ), 0);

    // 2: streaming, one-cycle latency, no bubbles
    seq[0] = 32'hA; seq[1] = 32'hB; seq[2] = 32'hC;
    a_dn.ready = 1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1, seq[i]);
      @(negedge CLK);
      chk("t2_in_ready", W'(a_up.ready), 1);
      if (i > 0) chk("t2_data", a_dn.data, seq[i-1]);
    end
    drive_a(0, '0);
    @(negedge CLK);
    chk("t2_last", a_dn.data, 32'hC);
    repeat (2) @(posedge CLK);
    #1 chk("t2_drained", W'(qa.size()), 0);

    // 3: backpressure fills the skid, refusal, then release
    a_dn.ready = 0;
    drive_a(1, 32'h1);
    drive_a(1, 32'h2);
    drive_a(1, 32'h3);
    @(negedge CLK);
    chk("t3_occ_full",   W'(a_occ), 2);
    chk("t3_in_ready_0", W'(a_up.ready), 0);
    @(posedge CLK); #1;
    a_dn.ready = 1;
    @(negedge CLK);
    chk("t3_in_ready_1", W'(a_up.ready), 1);
    chk("t3_head1", a_dn.data, 32'h1);
    drive_a(0, '0);
    @(negedge CLK);
    chk("t3_head2", a_dn.data, 32'h2);
    @(negedge CLK);
    chk("t3_head3", a_dn.data, 32'h3);
    repeat (2) @(posedge CLK);
    #1 chk("t3_drained", W'(qa.size()), 0);

    // 4: flush a full stage while 0x9 is offered
    a_dn.ready = 0;
    drive_a(1, 32'h1);
    drive_a(1, 32'h2);
    @(posedge CLK); #1;
    a_flush = 1; a_up.valid = 1; a_up.data = 32'h9;
    @(posedge CLK); #1;
    a_flush = 0; a_up.valid = 0;
    @(negedge CLK);
    chk("t4_occ",   W'(a_occ), 0);
    chk("t4_valid", W'(a_dn.valid), 0);
    chk("t4_data",  a_dn.data, '0);
    a_dn.ready = 1;
    repeat (4) @(posedge CLK);
    #1 chk("t4_no_stray", W'(a_dn.valid), 0);

    // 5: hold blocks pop but not push
    a_dn.ready = 0;
    drive_a(1, 32'h5);
    @(posedge CLK); #1;
    a_hold = 1; a_dn.ready = 1; a_up.data = 32'h6;
    @(negedge CLK);
    chk("t5_in_ready", W'(a_up.ready), 1);
    drive_a(0, '0);
    @(negedge CLK);
    chk("t5_occ",  W'(a_occ), 2);
    chk("t5_head", a_dn.data, 32'h5);
    @(posedge CLK); #1;
    a_hold = 0;
    repeat (3) @(posedge CLK);
    #1 chk("t5_drained", W'(qa.size()), 0);

    // 6: random traffic on the 3-deep stage, then asynchronous reset
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      b_up.valid = 1'($urandom_range(0, 1));
      b_up.data  = $urandom;
      b_dn.ready = 1'($urandom_range(0, 1));
    end
    @(posedge CLK); #1;
    b_dn.ready = 0; b_up.valid = 1; b_up.data = 32'h77;
    repeat (2) @(posedge CLK);
    #1 b_up.valid = 0;
    chk("t6_pre_rst_nonempty", W'(b_occ != 2'd0), 1);
    @(posedge CLK); #3;
    nRST = 1'b0;
    #1;
    qa.delete(); qb.delete();
    chk("t6_rst_valid",    W'(b_dn.valid), 0);
    chk("t6_rst_occ",      W'(b_occ), 0);
    chk("t6_rst_data",     b_dn.data, '0);
    chk("t6_rst_in_ready", W'(b_up.ready), 1);
    @(posedge CLK); #2;
    nRST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 chk("t6_post_occ", W'(b_occ), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
